// File: rtl/column_prefetch.sv
// column_prefetch: double-buffered texture column prefetcher for a POV LED strip.
// Ports: clk; reset (sync, active-low); theta/texture_idx select the column;
// frame_start marks a new strip frame; px_num selects the pixel read back on
// pixel (1-cycle latency, front bank); rom_addr/rom_data drive a 1-cycle ROM;
// fill_busy is high while the back bank fills; swap pulses when the banks
// exchange; miss_cnt saturates at 255 counting frames started mid-fill.
// Build option COLUMN_PREFETCH_BRIGHTNESS_EN adds an 8-bit brightness input
// that scales each colour channel as it is written into the back bank.
module column_prefetch #(
   parameter int LED_COUNT    = 52,
   parameter int TEX_WIDTH    = 128,
   parameter int NUM_TEXTURES = 5,
   parameter int ADDR_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        theta,
   input  logic [3:0]        texture_idx,
   input  logic              frame_start,
   input  logic [5:0]        px_num,
`ifdef COLUMN_PREFETCH_BRIGHTNESS_EN
   input  logic [7:0]        brightness,
`endif
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   output logic [23:0]       pixel,
   output logic              fill_busy,
   output logic              swap,
   output logic [7:0]        miss_cnt
);
   typedef enum logic [1:0] {IDLE, FILL, READY} state_t;
   state_t state, state_n;
   logic [5:0] cnt, cnt_n, lat_theta, wr_row;
   logic [3:0] tex, lat_tex;
   logic change, relatch, bank_sel, front_ok, wr_en;
   logic [23:0] bank0 [LED_COUNT];
   logic [23:0] bank1 [LED_COUNT];
   logic [23:0] wr_data, front_px;

   assign tex      = (32'(texture_idx) < NUM_TEXTURES) ? texture_idx : 4'd0;
   assign change   = {theta, tex} != {lat_theta, lat_tex};
   // Row term is forced to 0 outside FILL so the row-0 address is held.
   assign rom_addr = ADDR_W'((state == FILL ? 32'(cnt) : 32'd0) * TEX_WIDTH * NUM_TEXTURES
                             + 32'(lat_tex) * TEX_WIDTH + ((32'(lat_theta) * TEX_WIDTH) >> 6));
   assign fill_busy = state == FILL;
   assign swap      = state == READY && frame_start;
   // FILL cycle cnt writes the data returned for the row issued at cnt-1.
   assign wr_en     = reset && state == FILL && cnt != 6'd0;
   assign wr_row    = cnt - 6'd1;
   assign front_px  = bank_sel ? bank1[px_num] : bank0[px_num];

`ifdef COLUMN_PREFETCH_BRIGHTNESS_EN
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      return 8'((17'(c) * (17'(b) + 17'd1)) >> 8);
   endfunction
   assign wr_data = {scale(rom_data[23:16], brightness), scale(rom_data[15:8], brightness),
                     scale(rom_data[7:0], brightness)};
`else
   assign wr_data = rom_data;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      relatch = 1'b0;
      unique case (state)
         IDLE: if (change) begin
            relatch = 1'b1;
            state_n = FILL;
            cnt_n   = 6'd0;
         end
         FILL: if (change) begin
            relatch = 1'b1;
            cnt_n   = 6'd0;
         end else if (cnt == 6'(LED_COUNT)) state_n = READY;
         else cnt_n = cnt + 6'd1;
         READY: if (frame_start) state_n = IDLE;
         else if (change) begin
            relatch = 1'b1;
            state_n = FILL;
            cnt_n   = 6'd0;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 6'd0;
         lat_theta <= 6'd0;
         lat_tex   <= 4'd0;
         bank_sel  <= 1'b0;
         front_ok  <= 1'b0;
         pixel     <= 24'd0;
         miss_cnt  <= 8'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (relatch) {lat_theta, lat_tex} <= {theta, tex};
         if (swap) begin
            bank_sel <= ~bank_sel;
            front_ok <= 1'b1;
         end
         if (state == FILL && frame_start && miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
         // Front contents are untrusted after reset until a completed fill is swapped in.
         pixel <= (front_ok && 32'(px_num) < LED_COUNT) ? front_px : 24'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (bank_sel) bank0[wr_row] <= wr_data;
         else bank1[wr_row] <= wr_data;
      end
   end
endmodule

// File: tb/tb_column_prefetch.sv
// tb_column_prefetch: directed self-checking bench for column_prefetch.
module tb_column_prefetch;
   logic clk = 1'b0, reset = 1'b0, frame_start = 1'b0;
   logic [5:0] theta = 6'd0, px_num = 6'd0;
   logic [3:0] texture_idx = 4'd0;
   logic [15:0] rom_addr;
   logic [23:0] rom_data, pixel;
   logic fill_busy, swap, rom_force = 1'b0;
   logic [7:0] miss_cnt;
   int checks = 0, errs = 0;
`ifdef COLUMN_PREFETCH_BRIGHTNESS_EN
   logic [7:0] brightness = 8'd255;
`endif

   column_prefetch dut (
      .clk(clk), .reset(reset), .theta(theta), .texture_idx(texture_idx),
      .frame_start(frame_start), .px_num(px_num),
`ifdef COLUMN_PREFETCH_BRIGHTNESS_EN
      .brightness(brightness),
`endif
      .rom_addr(rom_addr), .rom_data(rom_data), .pixel(pixel),
      .fill_busy(fill_busy), .swap(swap), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom_force ? 24'hFF8040 : 24'(rom_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (fill_busy && n < 200) begin
         n++;
         tick();
      end
   endtask

   task automatic do_swap();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      checks++; if (pixel !== 24'd0) begin errs++; $display("FAIL reset_pixel got %0d want 0", pixel); end
      checks++; if (fill_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %0b want 0", fill_busy); end
      checks++; if (swap !== 1'b0) begin errs++; $display("FAIL reset_swap got %0b want 0", swap); end
      checks++; if (miss_cnt !== 8'd0) begin errs++; $display("FAIL reset_miss got %0d want 0", miss_cnt); end
      checks++; if (rom_addr !== 16'd0) begin errs++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
      reset = 1'b1;
      tick();
      checks++; if (fill_busy !== 1'b0) begin errs++; $display("FAIL reset_no_fill got %0b want 0", fill_busy); end
   endtask

   task automatic test_fill();
      int n;
      theta = 6'd5;
      texture_idx = 4'd2;
      tick();
      checks++; if (rom_addr !== 16'd266) begin errs++; $display("FAIL fill_row0_addr got %0d want 266", rom_addr); end
      checks++; if (pixel !== 24'd0) begin errs++; $display("FAIL fill_pre_swap_pixel got %0d want 0", pixel); end
      count_busy(n);
      checks++; if (n != 53) begin errs++; $display("FAIL fill_busy_len got %0d want 53", n); end
      checks++; if (rom_addr !== 16'd266) begin errs++; $display("FAIL ready_addr_hold got %0d want 266", rom_addr); end
      frame_start = 1'b1;
      #1;
      checks++; if (swap !== 1'b1) begin errs++; $display("FAIL fill_swap got %0b want 1", swap); end
      tick();
      frame_start = 1'b0;
      px_num = 6'd3;
      tick();
      checks++; if (pixel !== 24'd2186) begin errs++; $display("FAIL fill_px3 got %0d want 2186", pixel); end
      px_num = 6'd51;
      tick();
      checks++; if (pixel !== 24'd32906) begin errs++; $display("FAIL fill_px51 got %0d want 32906", pixel); end
      checks++; if (fill_busy !== 1'b0) begin errs++; $display("FAIL idle_after_swap got %0b want 0", fill_busy); end
   endtask

   task automatic test_restart();
      int n;
      theta = 6'd5;
      texture_idx = 4'd0;
      tick();
      repeat (20) tick();
      checks++; if (rom_addr !== 16'd12810) begin errs++; $display("FAIL restart_row20_addr got %0d want 12810", rom_addr); end
      theta = 6'd6;
      tick();
      checks++; if (rom_addr !== 16'd12) begin errs++; $display("FAIL restart_row0_addr got %0d want 12", rom_addr); end
      count_busy(n);
      checks++; if (n != 53) begin errs++; $display("FAIL restart_len got %0d want 53", n); end
      do_swap();
      px_num = 6'd0;
      tick();
      checks++; if (pixel !== 24'd12) begin errs++; $display("FAIL restart_px0 got %0d want 12", pixel); end
      px_num = 6'd1;
      tick();
      checks++; if (pixel !== 24'd652) begin errs++; $display("FAIL restart_px1 got %0d want 652", pixel); end
   endtask

   task automatic test_tex_clamp();
      int n;
      texture_idx = 4'd7;
      tick();
      tick();
      checks++; if (fill_busy !== 1'b0) begin errs++; $display("FAIL clamp_same_as_tex0 got %0b want 0", fill_busy); end
      px_num = 6'd60;
      tick();
      checks++; if (pixel !== 24'd0) begin errs++; $display("FAIL px60 got %0d want 0", pixel); end
      theta = 6'd1;
      texture_idx = 4'd9;
      tick();
      checks++; if (rom_addr !== 16'd2) begin errs++; $display("FAIL clamp_addr got %0d want 2", rom_addr); end
      count_busy(n);
      checks++; if (n != 53) begin errs++; $display("FAIL clamp_len got %0d want 53", n); end
      do_swap();
      px_num = 6'd2;
      tick();
      checks++; if (pixel !== 24'd1282) begin errs++; $display("FAIL clamp_px2 got %0d want 1282", pixel); end
   endtask

   task automatic test_miss();
      int n, swaps;
      swaps = 0;
      for (int i = 0; i < 300; i++) begin
         theta = ((i / 40) % 2 == 1) ? 6'd4 : 6'd3;
         frame_start = 1'b1;
         tick();
         if (swap) swaps++;
         if (i == 9) begin
            checks++; if (miss_cnt !== 8'd9) begin errs++; $display("FAIL miss_early got %0d want 9", miss_cnt); end
         end
      end
      frame_start = 1'b0;
      checks++; if (swaps != 0) begin errs++; $display("FAIL miss_swaps got %0d want 0", swaps); end
      checks++; if (miss_cnt !== 8'd255) begin errs++; $display("FAIL miss_sat got %0d want 255", miss_cnt); end
      checks++; if (pixel !== 24'd1282) begin errs++; $display("FAIL miss_front_kept got %0d want 1282", pixel); end
      count_busy(n);
      checks++; if (n >= 200) begin errs++; $display("FAIL miss_fill_timeout got %0d want <200", n); end
      checks++; if (miss_cnt !== 8'd255) begin errs++; $display("FAIL miss_hold got %0d want 255", miss_cnt); end
      checks++; if (pixel !== 24'd1282) begin errs++; $display("FAIL miss_front_ready got %0d want 1282", pixel); end
   endtask

   task automatic test_coincide();
      int n;
      theta = 6'd9;
      frame_start = 1'b1;
      px_num = 6'd0;
      #1;
      checks++; if (swap !== 1'b1) begin errs++; $display("FAIL coin_swap got %0b want 1", swap); end
      tick();
      frame_start = 1'b0;
      checks++; if (fill_busy !== 1'b0) begin errs++; $display("FAIL coin_idle got %0b want 0", fill_busy); end
      checks++; if (swap !== 1'b0) begin errs++; $display("FAIL coin_swap_one got %0b want 0", swap); end
      tick();
      checks++; if (fill_busy !== 1'b1) begin errs++; $display("FAIL coin_fill got %0b want 1", fill_busy); end
      checks++; if (rom_addr !== 16'd18) begin errs++; $display("FAIL coin_addr got %0d want 18", rom_addr); end
      checks++; if (pixel !== 24'd8) begin errs++; $display("FAIL coin_front got %0d want 8", pixel); end
      count_busy(n);
      checks++; if (n != 53) begin errs++; $display("FAIL coin_len got %0d want 53", n); end
      do_swap();
      tick();
      checks++; if (pixel !== 24'd18) begin errs++; $display("FAIL coin_px0 got %0d want 18", pixel); end
   endtask

   task automatic test_reset_mid_fill();
      int n;
      theta = 6'd12;
      tick();
      repeat (10) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++; if (fill_busy !== 1'b0) begin errs++; $display("FAIL rmf_busy got %0b want 0", fill_busy); end
      checks++; if (miss_cnt !== 8'd0) begin errs++; $display("FAIL rmf_miss got %0d want 0", miss_cnt); end
      tick();
      checks++; if (fill_busy !== 1'b1) begin errs++; $display("FAIL rmf_refill got %0b want 1", fill_busy); end
      checks++; if (rom_addr !== 16'd24) begin errs++; $display("FAIL rmf_addr got %0d want 24", rom_addr); end
      checks++; if (pixel !== 24'd0) begin errs++; $display("FAIL rmf_pixel got %0d want 0", pixel); end
      count_busy(n);
      checks++; if (n != 53) begin errs++; $display("FAIL rmf_len got %0d want 53", n); end
      checks++; if (pixel !== 24'd0) begin errs++; $display("FAIL rmf_ready_pixel got %0d want 0", pixel); end
      do_swap();
      tick();
      checks++; if (pixel !== 24'd24) begin errs++; $display("FAIL rmf_px0 got %0d want 24", pixel); end
   endtask

`ifdef COLUMN_PREFETCH_BRIGHTNESS_EN
   task automatic test_brightness();
      int n;
      rom_force = 1'b1;
      brightness = 8'd127;
      theta = 6'd20;
      tick();
      count_busy(n);
      checks++; if (n != 53) begin errs++; $display("FAIL bri_len got %0d want 53", n); end
      do_swap();
      tick();
      checks++; if (pixel !== 24'h7F4020) begin errs++; $display("FAIL bri_pixel got %h want 7f4020", pixel); end
      rom_force = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_restart();
      test_tex_clamp();
      test_miss();
      test_coincide();
      test_reset_mid_fill();
`ifdef COLUMN_PREFETCH_BRIGHTNESS_EN
      test_brightness();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
      $finish;
   end
endmodule

// File: doc/column_prefetch.md
COLUMN_PREFETCH -- requirements
Module: column_prefetch

Interface
REQ-001 The block SHALL have parameter LED_COUNT, default 52, meaning the number of pixels per column (max 63).
REQ-002 The block SHALL have parameter TEX_WIDTH, default 128, meaning the columns per texture (power of two).
REQ-003 The block SHALL have parameter NUM_TEXTURES, default 5, meaning the number of textures stored side by side in the texture ROM.
REQ-004 The block SHALL have parameter ADDR_W, default 16, meaning the texture ROM address width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port theta, input, 6 bits: angle index from the breakbeam angle generator.
REQ-008 The block SHALL have port texture_idx, input, 4 bits: texture selection from MMIO.
REQ-009 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse when the strip driver begins a new frame.
REQ-010 The block SHALL have port px_num, input, 6 bits: the pixel index requested by the strip driver.
REQ-011 The block SHALL have port rom_addr, output, ADDR_W bits: the texture ROM address.
REQ-012 The block SHALL have port rom_data, input, 24 bits: ROM read data, valid exactly 1 cycle after rom_addr.
REQ-013 The block SHALL have port pixel, output, 24 bits: GRB colour for px_num, delivered from the front bank.
REQ-014 The block SHALL have port fill_busy, output, 1 bit: high while the back bank is being filled.
REQ-015 The block SHALL have port swap, output, 1 bit: one-cycle pulse when the banks exchange.
REQ-016 The block SHALL have port miss_cnt, output, 8 bits: a saturating count of frames started without a swap while a fill was pending.

Function
REQ-017 The block SHALL hold two banks of LED_COUNT x 24-bit entries, a front bank (read) and a back bank (filled), selected by an internal bank_sel bit.
REQ-018 The block SHALL compute col = (theta * TEX_WIDTH) >> 6 and tex = (texture_idx < NUM_TEXTURES) ? texture_idx : 0.
REQ-019 The block SHALL compute rom_addr = row * TEX_WIDTH * NUM_TEXTURES + tex * TEX_WIDTH + col, truncated to ADDR_W bits.
REQ-020 The block SHALL implement states IDLE, FILL, READY.
REQ-021 In IDLE, a change of {theta, tex} from the last latched value SHALL latch the new value and enter FILL on the next cycle.
REQ-022 In FILL, the block SHALL issue rows 0..LED_COUNT-1 on consecutive cycles and write rom_data for row r into back-bank entry r one cycle after issue; after the last write it SHALL enter READY.
REQ-023 A fill SHALL take exactly LED_COUNT+1 cycles from entering FILL to entering READY.
REQ-024 fill_busy SHALL be high in FILL only.
REQ-025 If {theta, tex} changes during FILL, the block SHALL relatch the new value and restart at row 0 on the next cycle, discarding partial data.
REQ-026 In READY, frame_start SHALL toggle bank_sel, pulse swap the same cycle, and return the state to IDLE.
REQ-027 If {theta, tex} changes during READY without frame_start, the block SHALL relatch and re-enter FILL.
REQ-028 If a {theta, tex} change and frame_start coincide in READY, the swap SHALL win and the change SHALL be handled from IDLE on the next cycle.
REQ-029 frame_start in FILL SHALL increment miss_cnt, saturating at 255; frame_start in IDLE SHALL be ignored.
REQ-030 pixel SHALL be registered as front[px_num] with 1-cycle latency; a px_num >= LED_COUNT SHALL yield 0.
REQ-031 Front-bank contents SHALL never change except via swap.
REQ-032 rom_addr SHALL hold the row-0 address of the latched value outside FILL.

Reset
REQ-033 When reset is low at a clk edge, the block SHALL set the state to IDLE, bank_sel to 0, pixel to 0, fill_busy to 0, swap to 0, miss_cnt to 0, and the latched {theta, tex} to {0, 0}.
REQ-034 After reset, the first cycle the block samples a {theta, tex} different from {0, 0} SHALL start a fill.
REQ-035 Reset mid-FILL SHALL abort the fill; bank contents need not be cleared, but pixel SHALL read 0 until the first swap.

Configuration
REQ-036 With macro COLUMN_PREFETCH_BRIGHTNESS_EN defined, the block SHALL add an 8-bit input brightness, and each channel written into the back bank SHALL be (c * (brightness + 1)) >> 8, with brightness sampled in the same cycle as the write.
REQ-037 With COLUMN_PREFETCH_BRIGHTNESS_EN undefined, the brightness port SHALL be absent and rom_data SHALL be written unmodified.
REQ-038 Fill timing SHALL be identical in both builds.

Verification
REQ-039 Scenario: reset, theta=5, tex=2, model ROM data = address -> fill_busy high for 53 cycles; after frame_start, pixel for px_num=3 equals 3*640 + 256 + 10 = 2186.
REQ-040 Scenario: theta changes 5->6 at fill row 20 -> the fill restarts, READY is reached 53 cycles after the change, and px_num=0 reads address 12.
REQ-041 Scenario: frame_start during FILL, repeated 300 times -> no swap, the front bank is unchanged, and miss_cnt=255.
REQ-042 Scenario: texture_idx=7 -> the block behaves as tex 0; px_num=60 -> pixel=0.
REQ-043 Scenario: a theta change coincides with frame_start in READY -> swap pulses, then FILL starts on the next cycle with the new theta.
REQ-044 Scenario: in the COLUMN_PREFETCH_BRIGHTNESS_EN build, brightness=127 and rom_data=0xFF8040 -> the stored pixel is 0x7F4020.
